// File: rtl/microsequencer_pkg.sv
// Shared constants for the microsequencer: next-state modes, condition
// selects and default microstate parameters.
package microsequencer_pkg;

  // Default geometry and special microstates
  localparam int STATE_W_DEF     = 5;
  localparam int RESET_STATE_DEF = 0;
  localparam int TRAP_STATE_DEF  = 31;
  localparam int WAIT_MAX_DEF    = 15;

  // Wait counter is wide enough for WAIT_MAX up to 255
  localparam int CNT_W = 8;

  // Next-state modes {N2,N1,N0}
  localparam logic [2:0] N_ENC  = 3'b000;
  localparam logic [2:0] N_CR   = 3'b001;
  localparam logic [2:0] N_INC  = 3'b010;
  localparam logic [2:0] N_CBR  = 3'b011;
  localparam logic [2:0] N_CENC = 3'b100;
  localparam logic [2:0] N_WAIT = 3'b101;
  localparam logic [2:0] N_RET  = 3'b110;
  localparam logic [2:0] N_CALL = 3'b111;

  // Condition selects {S1,S0}
  localparam logic [1:0] S_MOC   = 2'b00;
  localparam logic [1:0] S_BCOND = 2'b01;
  localparam logic [1:0] S_ANNUL = 2'b10;
  localparam logic [1:0] S_TRUE  = 2'b11;

endpackage

// File: rtl/microseq_next_sel.sv
// Combinational next-microstate selection: condition mux, incrementer and
// the per-mode next-state choice, including trap redirection for wait
// timeout and return-without-call.
module microseq_next_sel
  import microsequencer_pkg::*;
#(
  parameter int STATE_W    = STATE_W_DEF,
  parameter int TRAP_STATE = TRAP_STATE_DEF
) (
  input  logic [2:0]         n_sel,
  input  logic               inv,
  input  logic [1:0]         s_sel,
  input  logic [STATE_W-1:0] cr,
  input  logic [STATE_W-1:0] enc_state,
  input  logic               moc,
  input  logic               bcond,
  input  logic               annul,
  input  logic [STATE_W-1:0] state,
  input  logic [STATE_W-1:0] ret_addr,
  input  logic               ret_valid,
  input  logic               wait_at_limit,
  output logic [STATE_W-1:0] next_state,
  output logic [STATE_W-1:0] inc,
  output logic               cond,
  output logic               timeout,
  output logic               ret_err
);

  localparam logic [STATE_W-1:0] TRAP = STATE_W'(TRAP_STATE);

  logic c_raw;

  // Select the raw condition and apply optional inversion
  always_comb begin
    c_raw = 1'b1;
    case (s_sel)
      S_MOC:   c_raw = moc;
      S_BCOND: c_raw = bcond;
      S_ANNUL: c_raw = annul;
      S_TRUE:  c_raw = 1'b1;
      default: c_raw = 1'b1;
    endcase
    cond = c_raw ^ inv;
    inc  = state + 1'b1;  // wraps naturally at 2^STATE_W
  end

  // Choose the next microstate for the current mode
  always_comb begin
    next_state = state;
    timeout    = 1'b0;
    ret_err    = 1'b0;
    case (n_sel)
      N_ENC:  next_state = enc_state;
      N_CR:   next_state = cr;
      N_INC:  next_state = inc;
      N_CBR:  next_state = cond ? cr : inc;
      N_CENC: next_state = cond ? cr : enc_state;
      N_WAIT: begin
        // A completing condition on the limit cycle still advances normally
        if (cond) begin
          next_state = inc;
        end else if (wait_at_limit) begin
          next_state = TRAP;
          timeout    = 1'b1;
        end else begin
          next_state = state;
        end
      end
      N_RET: begin
        if (ret_valid) begin
          next_state = ret_addr;
        end else begin
          next_state = TRAP;
          ret_err    = 1'b1;
        end
      end
      N_CALL: next_state = cr;
      default: next_state = state;
    endcase
  end

endmodule

// File: rtl/microsequencer.sv
// Microprogram next-state sequencer: registers the next microstate, keeps a
// single-level return address and supervises memory waits with a timeout.
module microsequencer
  import microsequencer_pkg::*;
#(
  parameter int STATE_W     = STATE_W_DEF,
  parameter int RESET_STATE = RESET_STATE_DEF,
  parameter int TRAP_STATE  = TRAP_STATE_DEF,
  parameter int WAIT_MAX    = WAIT_MAX_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         n_sel,
  input  logic               inv,
  input  logic [1:0]         s_sel,
  input  logic [STATE_W-1:0] cr,
  input  logic [STATE_W-1:0] enc_state,
  input  logic               moc,
  input  logic               bcond,
  input  logic               annul,
  output logic [STATE_W-1:0] state,
  output logic               mem_timeout,
  output logic               ret_err
);

  logic [STATE_W-1:0] next_state;
  logic [STATE_W-1:0] inc;
  logic [STATE_W-1:0] ret_addr;
  logic               ret_valid;
  logic [CNT_W-1:0]   wait_cnt;
  logic               cond;
  logic               timeout_c;
  logic               ret_err_c;
  logic               wait_at_limit;
  logic               wait_stall;

  assign wait_at_limit = (wait_cnt == CNT_W'(WAIT_MAX - 1));
  assign wait_stall    = (n_sel == N_WAIT) && !cond;

  microseq_next_sel #(
    .STATE_W    (STATE_W),
    .TRAP_STATE (TRAP_STATE)
  ) u_next_sel (
    .n_sel         (n_sel),
    .inv           (inv),
    .s_sel         (s_sel),
    .cr            (cr),
    .enc_state     (enc_state),
    .moc           (moc),
    .bcond         (bcond),
    .annul         (annul),
    .state         (state),
    .ret_addr      (ret_addr),
    .ret_valid     (ret_valid),
    .wait_at_limit (wait_at_limit),
    .next_state    (next_state),
    .inc           (inc),
    .cond          (cond),
    .timeout       (timeout_c),
    .ret_err       (ret_err_c)
  );

  // Microstate register and one-cycle error pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= STATE_W'(RESET_STATE);
      mem_timeout <= 1'b0;
      ret_err     <= 1'b0;
    end else begin
      state       <= next_state;
      mem_timeout <= timeout_c;
      ret_err     <= ret_err_c;
    end
  end

  // Wait counter: counts stalled wait cycles, restarts on any other cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (wait_stall && !wait_at_limit) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // Single-level return address: call saves state+1, return consumes it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ret_addr  <= '0;
      ret_valid <= 1'b0;
    end else if (n_sel == N_CALL) begin
      ret_addr  <= inc;
      ret_valid <= 1'b1;
    end else if (n_sel == N_RET) begin
      ret_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_microsequencer.sv
// Bench for the microsequencer: directed vectors, a behavioural reference
// model compared every cycle, and literal expectations at key points.
module tb_microsequencer;

  localparam int W        = 5;
  localparam int WAIT_MAX = 15;
  localparam int TRAP     = 31;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]   n_sel = 3'd0;
  logic         inv = 1'b0;
  logic [1:0]   s_sel = 2'd0;
  logic [W-1:0] cr = '0;
  logic [W-1:0] enc_state = '0;
  logic         moc = 1'b0;
  logic         bcond = 1'b0;
  logic         annul = 1'b0;
  logic [W-1:0] state;
  logic         mem_timeout;
  logic         ret_err;

  microsequencer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .n_sel       (n_sel),
    .inv         (inv),
    .s_sel       (s_sel),
    .cr          (cr),
    .enc_state   (enc_state),
    .moc         (moc),
    .bcond       (bcond),
    .annul       (annul),
    .state       (state),
    .mem_timeout (mem_timeout),
    .ret_err     (ret_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_state = 0;
  int m_ret_addr = 0;
  bit m_ret_valid = 0;
  int m_wait = 0;
  bit m_to = 0;
  bit m_re = 0;

  always @(posedge clk or negedge reset_n) begin : model
    int c;
    int nx;
    int nxt_inc;
    if (!reset_n) begin
      m_state     <= 0;
      m_ret_addr  <= 0;
      m_ret_valid <= 0;
      m_wait      <= 0;
      m_to        <= 0;
      m_re        <= 0;
    end else begin
      case (s_sel)
        2'd0: c = moc;
        2'd1: c = bcond;
        2'd2: c = annul;
        default: c = 1;
      endcase
      if (inv) c = 1 - c;
      nxt_inc = (m_state + 1) % 32;
      m_to <= 0;
      m_re <= 0;
      m_wait <= 0;
      nx = m_state;
      case (n_sel)
        3'd0: nx = enc_state;
        3'd1: nx = cr;
        3'd2: nx = nxt_inc;
        3'd3: nx = c ? int'(cr) : nxt_inc;
        3'd4: nx = c ? int'(cr) : int'(enc_state);
        3'd5: begin
          if (c) nx = nxt_inc;
          else if (m_wait == WAIT_MAX - 1) begin
            nx = TRAP;
            m_to <= 1;
          end else begin
            nx = m_state;
            m_wait <= m_wait + 1;
          end
        end
        3'd6: begin
          if (m_ret_valid) nx = m_ret_addr;
          else begin
            nx = TRAP;
            m_re <= 1;
          end
          m_ret_valid <= 0;
        end
        default: begin
          nx = cr;
          m_ret_addr  <= nxt_inc;
          m_ret_valid <= 1;
        end
      endcase
      m_state <= nx;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if ($time > 20) begin
      chk("model_state", state, m_state);
      chk("model_mem_timeout", mem_timeout, m_to);
      chk("model_ret_err", ret_err, m_re);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input logic [2:0] n, input logic [1:0] s, input logic iv);
    n_sel = n;
    s_sel = s;
    inv   = iv;
  endtask

  task automatic jump_to(input int target);
    set_mode(3'b001, 2'b11, 1'b0);
    cr = W'(target);
    step();
    chk("jump_setup", state, target);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Async reset from state 7
    jump_to(7);
    reset_n = 1'b0;
    #1;
    chk("reset_async_state", state, 0);
    chk("reset_mem_timeout", mem_timeout, 0);
    chk("reset_ret_err", ret_err, 0);
    step();
    step();
    chk("reset_hold_state", state, 0);
    reset_n = 1'b1;
    set_mode(3'b010, 2'b00, 1'b0);
    step();
    chk("release_inc", state, 1);

    // Increment and wrap
    jump_to(30);
    set_mode(3'b010, 2'b00, 1'b0);
    step();
    chk("inc_30", state, 31);
    step();
    chk("inc_wrap", state, 0);

    // Conditional branches
    jump_to(4);
    set_mode(3'b011, 2'b01, 1'b0);
    cr = 5'd18; bcond = 1'b1;
    step();
    chk("cbr_taken", state, 18);
    jump_to(4);
    set_mode(3'b011, 2'b01, 1'b1);
    cr = 5'd18;
    step();
    chk("cbr_inverted", state, 5);
    set_mode(3'b100, 2'b01, 1'b1);
    enc_state = 5'd9;
    step();
    chk("cenc_enc", state, 9);
    set_mode(3'b011, 2'b10, 1'b0);
    annul = 1'b1; cr = 5'd3;
    step();
    chk("cbr_annul", state, 3);
    set_mode(3'b000, 2'b00, 1'b0);
    enc_state = 5'd22;
    step();
    chk("enc_dispatch", state, 22);

    // Wait: three stalls then completion
    jump_to(12);
    set_mode(3'b101, 2'b00, 1'b0);
    moc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_hold", state, 12);
    end
    moc = 1'b1;
    step();
    chk("wait_done", state, 13);
    chk("wait_done_no_to", mem_timeout, 0);

    // Wait timeout after WAIT_MAX stalls
    moc = 1'b0;
    for (int i = 0; i < WAIT_MAX - 1; i++) begin
      step();
      chk("to_hold", state, 13);
      chk("to_quiet", mem_timeout, 0);
    end
    step();
    chk("to_trap", state, TRAP);
    chk("to_pulse", mem_timeout, 1);
    set_mode(3'b010, 2'b00, 1'b0);
    step();
    chk("to_pulse_end", mem_timeout, 0);
    chk("to_after_inc", state, 0);

    // Completion on the limit cycle wins over timeout
    jump_to(8);
    set_mode(3'b101, 2'b00, 1'b0);
    moc = 1'b0;
    repeat (WAIT_MAX - 1) step();
    chk("limit_hold", state, 8);
    moc = 1'b1;
    step();
    chk("limit_advance", state, 9);
    chk("limit_no_to", mem_timeout, 0);

    // Call / return / return without call
    jump_to(6);
    set_mode(3'b111, 2'b00, 1'b0);
    cr = 5'd20;
    step();
    chk("call_target", state, 20);
    set_mode(3'b110, 2'b00, 1'b0);
    step();
    chk("ret_addr", state, 7);
    chk("ret_ok_no_err", ret_err, 0);
    step();
    chk("ret_trap", state, TRAP);
    chk("ret_err_pulse", ret_err, 1);
    set_mode(3'b010, 2'b00, 1'b0);
    step();
    chk("ret_err_end", ret_err, 0);

    // Call overwrites the saved address
    jump_to(2);
    set_mode(3'b111, 2'b00, 1'b0);
    cr = 5'd10;
    step();
    cr = 5'd15;
    step();
    chk("call2_target", state, 15);
    set_mode(3'b110, 2'b00, 1'b0);
    step();
    chk("call2_ret", state, 11);

    // Reset mid-wait restarts the full timeout window
    jump_to(12);
    set_mode(3'b101, 2'b00, 1'b0);
    moc = 1'b0;
    repeat (10) step();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    chk("midwait_reset", state, 0);
    for (int i = 0; i < WAIT_MAX - 1; i++) begin
      step();
      chk("rst_wait_quiet", mem_timeout, 0);
    end
    chk("rst_wait_hold", state, 0);
    step();
    chk("rst_wait_trap", state, TRAP);
    chk("rst_wait_pulse", mem_timeout, 1);

    // Reset mid-call discards the return address
    set_mode(3'b111, 2'b00, 1'b0);
    cr = 5'd17;
    step();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    set_mode(3'b110, 2'b00, 1'b0);
    step();
    chk("midcall_ret_trap", state, TRAP);
    chk("midcall_ret_err", ret_err, 1);
    set_mode(3'b010, 2'b00, 1'b0);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
